// File: rtl/keyboard_fifo_ctrl_if.sv
// CPU I/O bus command port of the keyboard FIFO controller.
// Handshake: a request is taken on the rising edge where iBUS_REQ=1 and oBUS_BUSY=0.
// The command is latched on that edge. Exactly one cycle later oBUS_VALID pulses for one cycle with oBUS_DATA.
// A request presented while busy is not taken, so the master holds or retries it.
interface keyboard_fifo_ctrl_if;
    logic        iBUS_REQ;
    logic [1:0]  iBUS_CMD;
    logic        oBUS_BUSY;
    logic        oBUS_VALID;
    logic [31:0] oBUS_DATA;

    modport master (
        output iBUS_REQ,
        output iBUS_CMD,
        input  oBUS_BUSY,
        input  oBUS_VALID,
        input  oBUS_DATA
    );

    modport slave (
        input  iBUS_REQ,
        input  iBUS_CMD,
        output oBUS_BUSY,
        output oBUS_VALID,
        output oBUS_DATA
    );
endinterface

// File: rtl/keyboard_fifo_ctrl.sv
// Sequences an external keyboard scancode FIFO between the PS/2 receiver and the CPU bus.
// Provides overflow tracking, bus read/status/flush commands, and a maskable acknowledged interrupt.
module keyboard_fifo_ctrl #(
    parameter int D_N   = 4,
    parameter int DEPTH = 16
) (
    input  logic           iCLOCK,
    input  logic           inRESET,
    input  logic           iKEY_VALID,
    input  logic [7:0]     iKEY_DATA,
    output logic           oFIFO_WR_EN,
    output logic [7:0]     oFIFO_WR_DATA,
    input  logic           iFIFO_FULL,
    input  logic           iFIFO_EMPTY,
    input  logic [D_N-1:0] iFIFO_COUNT,
    output logic           oFIFO_RD_EN,
    input  logic [7:0]     iFIFO_RD_DATA,
    output logic           oFIFO_REMOVE,
    keyboard_fifo_ctrl_if.slave bus,
    input  logic           iIRQ_MASK,
    output logic           oIRQ_VALID,
    input  logic           iIRQ_ACK,
    output logic [1:0]     oDEBUG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] CMD_READ   = 2'b00;
    localparam logic [1:0] CMD_STATUS = 2'b01;
    localparam logic [1:0] CMD_FLUSH  = 2'b10;
    localparam logic [1:0] CMD_CLROVF = 2'b11;

    state_t      r_state;
    logic [1:0]  r_cmd;
    logic        r_busy;
    logic        r_bus_valid;
    logic [31:0] r_capture;
    logic        r_overflow;
    logic        r_irq_pending;
    logic        r_irq_valid;

    logic        w_exec;
    logic        w_flush;
    logic        w_pop;
    logic        w_wr_en;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic [31:0] w_status;
    logic [31:0] w_capture;

    assign w_exec    = (r_state == ST_EXEC);
    assign w_flush   = w_exec && (r_cmd == CMD_FLUSH);
    assign w_pop     = w_exec && (r_cmd == CMD_READ) && !iFIFO_EMPTY;
    assign w_wr_en   = iKEY_VALID && !iFIFO_FULL && !w_flush;
    // A key that arrives during a flush is dropped on purpose and is not an overflow.
    assign w_ovf_set = iKEY_VALID && iFIFO_FULL && !w_flush;
    assign w_ovf_clr = w_exec && ((r_cmd == CMD_FLUSH) || (r_cmd == CMD_CLROVF));

    assign oFIFO_WR_DATA = iKEY_DATA;
    assign oFIFO_WR_EN   = w_wr_en;
    assign oFIFO_RD_EN   = w_pop;
    assign oFIFO_REMOVE  = w_flush;

    always_comb begin
        w_status = '0;
        // The count port wraps at DEPTH, so FULL selects the true entry count.
        w_status[D_N:0] = iFIFO_FULL ? (D_N+1)'(DEPTH) : {1'b0, iFIFO_COUNT};
        w_status[16] = iFIFO_EMPTY;
        w_status[17] = iFIFO_FULL;
        w_status[18] = r_overflow;
        w_status[19] = r_irq_pending;
    end

    always_comb begin
        w_capture = '0;
        case (r_cmd)
            CMD_READ:   if (!iFIFO_EMPTY) w_capture = {23'b0, 1'b1, iFIFO_RD_DATA};
            CMD_STATUS: w_capture = w_status;
            default:    w_capture = '0;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state       <= ST_IDLE;
            r_cmd         <= CMD_READ;
            r_busy        <= 1'b0;
            r_bus_valid   <= 1'b0;
            r_capture     <= '0;
            r_overflow    <= 1'b0;
            r_irq_pending <= 1'b0;
            r_irq_valid   <= 1'b0;
        end else begin
            r_bus_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.iBUS_REQ) begin
                        r_cmd   <= bus.iBUS_CMD;
                        r_state <= ST_EXEC;
                        r_busy  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_capture   <= w_capture;
                    r_bus_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A fresh overflow on the same edge as a clear command is kept.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_wr_en) begin
                r_irq_pending <= 1'b1;
            end else if (w_flush || iIRQ_ACK) begin
                r_irq_pending <= 1'b0;
            end

            r_irq_valid <= r_irq_pending && !iIRQ_MASK;
        end
    end

    assign bus.oBUS_BUSY  = r_busy;
    assign bus.oBUS_VALID = r_bus_valid;
    assign bus.oBUS_DATA  = r_capture;
    assign oIRQ_VALID     = r_irq_valid;
    assign oDEBUG_STATE   = r_state;

endmodule

// File: tb/tb_keyboard_fifo_ctrl.sv
// Directed bench for keyboard_fifo_ctrl with a behavioural 16-entry FIFO.
// It keeps a queue of expected bus responses.
module tb_keyboard_fifo_ctrl;

    logic       iCLOCK;
    logic       inRESET;
    logic       iKEY_VALID;
    logic [7:0] iKEY_DATA;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_count;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_remove;
    logic       iIRQ_MASK;
    logic       oIRQ_VALID;
    logic       iIRQ_ACK;
    logic [1:0] dbg_state;

    keyboard_fifo_ctrl_if bus();

    keyboard_fifo_ctrl #(.D_N(4), .DEPTH(16)) dut (
        .iCLOCK        (iCLOCK),
        .inRESET       (inRESET),
        .iKEY_VALID    (iKEY_VALID),
        .iKEY_DATA     (iKEY_DATA),
        .oFIFO_WR_EN   (fifo_wr_en),
        .oFIFO_WR_DATA (fifo_wr_data),
        .iFIFO_FULL    (fifo_full),
        .iFIFO_EMPTY   (fifo_empty),
        .iFIFO_COUNT   (fifo_count),
        .oFIFO_RD_EN   (fifo_rd_en),
        .iFIFO_RD_DATA (fifo_rd_data),
        .oFIFO_REMOVE  (fifo_remove),
        .bus           (bus),
        .iIRQ_MASK     (iIRQ_MASK),
        .oIRQ_VALID    (oIRQ_VALID),
        .iIRQ_ACK      (iIRQ_ACK),
        .oDEBUG_STATE  (dbg_state)
    );

    // clock / reset
    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    // behavioural FIFO standing in for the external instance
    logic [7:0] f_mem [16];
    logic [3:0] f_rd;
    logic [3:0] f_wr;
    logic [4:0] f_cnt;
    logic       f_push;
    logic       f_pop;

    assign f_push       = fifo_wr_en && (f_cnt != 5'd16);
    assign f_pop        = fifo_rd_en && (f_cnt != 5'd0);
    assign fifo_full    = (f_cnt == 5'd16);
    assign fifo_empty   = (f_cnt == 5'd0);
    assign fifo_count   = f_cnt[3:0];
    assign fifo_rd_data = f_mem[f_rd];

    always @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            f_rd  <= 4'd0;
            f_wr  <= 4'd0;
            f_cnt <= 5'd0;
        end else if (fifo_remove) begin
            f_rd  <= 4'd0;
            f_wr  <= 4'd0;
            f_cnt <= 5'd0;
        end else begin
            if (f_push) begin
                f_mem[f_wr] <= fifo_wr_data;
                f_wr        <= f_wr + 4'd1;
            end
            if (f_pop) f_rd <= f_rd + 4'd1;
            f_cnt <= f_cnt + 5'(f_push) - 5'(f_pop);
        end
    end

    // pulse monitors
    int n_rd;
    int n_bad_pop;
    int n_remove;
    int n_wr;

    initial begin
        n_rd = 0;
        n_bad_pop = 0;
        n_remove = 0;
        n_wr = 0;
    end

    always @(posedge iCLOCK) begin
        if (fifo_rd_en) n_rd <= n_rd + 1;
        if (fifo_rd_en && fifo_empty) n_bad_pop <= n_bad_pop + 1;
        if (fifo_remove) n_remove <= n_remove + 1;
        if (fifo_wr_en) n_wr <= n_wr + 1;
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        @(negedge iCLOCK);
    endtask

    // driver tasks
    task automatic key(input logic [7:0] d);
        iKEY_VALID = 1'b1;
        iKEY_DATA  = d;
        tick();
        iKEY_VALID = 1'b0;
    endtask

    task automatic ack_irq();
        iIRQ_ACK = 1'b1;
        tick();
        iIRQ_ACK = 1'b0;
    endtask

    task automatic bus_cmd_k(input logic [1:0] cmd, input logic [31:0] exp, input string tag,
                             input logic kv, input logic [7:0] kd);
        int waited;
        logic [31:0] want;
        exp_q.push_back(exp);
        bus.iBUS_REQ = 1'b1;
        bus.iBUS_CMD = cmd;
        tick();
        bus.iBUS_REQ = 1'b0;
        check({tag, "_busy_exec"}, 32'(bus.oBUS_BUSY), 32'd1);
        check({tag, "_no_early_valid"}, 32'(bus.oBUS_VALID), 32'd0);
        iKEY_VALID = kv;
        iKEY_DATA  = kd;
        if (kv) begin
            #1;
            check({tag, "_exec_wr_en"}, 32'(fifo_wr_en), 32'd0);
        end
        tick();
        iKEY_VALID = 1'b0;
        waited = 0;
        while (!bus.oBUS_VALID && waited < 5) begin
            tick();
            waited++;
        end
        check({tag, "_latency"}, 32'(waited), 32'd0);
        want = exp_q.pop_front();
        if (bus.oBUS_VALID) check({tag, "_data"}, bus.oBUS_DATA, want);
        tick();
        check({tag, "_valid_one_cycle"}, 32'(bus.oBUS_VALID), 32'd0);
        check({tag, "_idle_after"}, 32'(bus.oBUS_BUSY), 32'd0);
    endtask

    task automatic bus_op(input logic [1:0] cmd, input logic [31:0] exp, input string tag);
        bus_cmd_k(cmd, exp, tag, 1'b0, 8'h00);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.oBUS_BUSY), 32'd0);
        check({tag, "_valid"}, 32'(bus.oBUS_VALID), 32'd0);
        check({tag, "_data"}, bus.oBUS_DATA, 32'd0);
        check({tag, "_irq"}, 32'(oIRQ_VALID), 32'd0);
        check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        check({tag, "_remove"}, 32'(fifo_remove), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    logic [7:0] kv [16];
    int n0;
    int n1;
    logic [31:0] want_h;

    initial begin
        checks = 0;
        errors = 0;
        inRESET = 1'b0;
        iKEY_VALID = 1'b0;
        iKEY_DATA = 8'h00;
        bus.iBUS_REQ = 1'b0;
        bus.iBUS_CMD = 2'b00;
        iIRQ_MASK = 1'b0;
        iIRQ_ACK = 1'b0;
        repeat (3) @(negedge iCLOCK);
        check_outputs_zero("reset");
        inRESET = 1'b1;
        tick();

        // three keys, four reads
        key(8'h1C);
        key(8'h32);
        key(8'h21);
        n0 = n_rd;
        bus_op(2'b00, 32'h0000_011C, "rd0");
        bus_op(2'b00, 32'h0000_0132, "rd1");
        bus_op(2'b00, 32'h0000_0121, "rd2");
        bus_op(2'b00, 32'h0000_0000, "rd_empty");
        check("rd_pulses", 32'(n_rd - n0), 32'd3);

        // fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            kv[i] = 8'($urandom_range(0, 255));
            key(kv[i]);
        end
        ack_irq();
        bus_op(2'b01, 32'h0002_0010, "stat_full");
        iKEY_VALID = 1'b1;
        iKEY_DATA  = 8'hEE;
        #1;
        check("wr_blocked_full", 32'(fifo_wr_en), 32'd0);
        tick();
        iKEY_VALID = 1'b0;
        bus_op(2'b01, 32'h0006_0010, "stat_ovf");

        // clear overflow, contents intact
        bus_op(2'b11, 32'h0, "clr_ovf");
        bus_op(2'b01, 32'h0002_0010, "stat_after_clr");
        for (int i = 0; i < 16; i++) begin
            want_h = {23'b0, 1'b1, kv[i]};
            bus_op(2'b00, want_h, "drain");
        end
        bus_op(2'b01, 32'h0001_0000, "stat_drained");

        // flush with a key strobed in the flush cycle
        for (int i = 0; i < 5; i++) key(8'(8'h40 + i));
        n0 = n_remove;
        n1 = n_wr;
        bus_cmd_k(2'b10, 32'h0, "flush", 1'b1, 8'h55);
        check("remove_pulses", 32'(n_remove - n0), 32'd1);
        check("flush_key_dropped", 32'(n_wr - n1), 32'd0);
        bus_op(2'b01, 32'h0001_0000, "stat_after_flush");

        // interrupt
        check("irq_idle", 32'(oIRQ_VALID), 32'd0);
        iKEY_VALID = 1'b1;
        iKEY_DATA  = 8'h61;
        tick();
        iKEY_VALID = 1'b0;
        check("irq_1edge", 32'(oIRQ_VALID), 32'd0);
        tick();
        check("irq_2edge", 32'(oIRQ_VALID), 32'd1);
        ack_irq();
        tick();
        check("irq_ack", 32'(oIRQ_VALID), 32'd0);
        key(8'h62);
        tick();
        check("irq_rearm", 32'(oIRQ_VALID), 32'd1);
        iIRQ_ACK   = 1'b1;
        iKEY_VALID = 1'b1;
        iKEY_DATA  = 8'h63;
        tick();
        iIRQ_ACK   = 1'b0;
        iKEY_VALID = 1'b0;
        tick();
        tick();
        check("irq_write_beats_ack", 32'(oIRQ_VALID), 32'd1);
        iIRQ_MASK = 1'b1;
        tick();
        tick();
        check("irq_masked", 32'(oIRQ_VALID), 32'd0);
        bus_op(2'b01, 32'h0008_0003, "stat_masked");
        iIRQ_MASK = 1'b0;
        ack_irq();
        bus_op(2'b10, 32'h0, "flush2");

        // request held high: one accept every three cycles
        bus.iBUS_REQ = 1'b1;
        bus.iBUS_CMD = 2'b01;
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 0) exp_q.push_back(32'h0001_0000);
            tick();
            check("held_busy", 32'(bus.oBUS_BUSY), (i % 3 != 2) ? 32'd1 : 32'd0);
            check("held_valid", 32'(bus.oBUS_VALID), (i % 3 == 1) ? 32'd1 : 32'd0);
            if (bus.oBUS_VALID && exp_q.size() > 0) begin
                want_h = exp_q.pop_front();
                check("held_data", bus.oBUS_DATA, want_h);
            end
        end
        bus.iBUS_REQ = 1'b0;
        tick();

        // reset while in EXEC
        bus.iBUS_REQ = 1'b1;
        bus.iBUS_CMD = 2'b00;
        tick();
        bus.iBUS_REQ = 1'b0;
        check("pre_rst_busy", 32'(bus.oBUS_BUSY), 32'd1);
        inRESET = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        tick();
        inRESET = 1'b1;
        n0 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.oBUS_VALID) n0++;
        end
        check("no_resp_after_rst", 32'(n0), 32'd0);

        check("never_pop_empty", 32'(n_bad_pop), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
